// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus arbiter: bus widths, source codes
// and the round-robin pick helper.
package cdb_arbiter_pkg;

  localparam int ROB_ADDR_W = 4;   // ROBAddrBus
  localparam int DATA_BUS_W = 32;  // DataBus

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LS  = 1'b1
  } src_e;

  // On a tie the source that did not win last time gets the bus.
  function automatic src_e rr_pick(input src_e last);
    return (last == SRC_LS) ? SRC_ALU : SRC_LS;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side pushes, flow control and the registered CDB broadcast.
interface cdb_arbiter_if #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32
);
  logic              rdy;
  logic              clr_i;
  logic              alu_en_i;
  logic [ID_W-1:0]   alu_id_i;
  logic [DATA_W-1:0] alu_data_i;
  logic [DATA_W-1:0] alu_pc_i;
  logic              alu_cond_i;
  logic              alu_full_o;
  logic              ls_en_i;
  logic [ID_W-1:0]   ls_id_i;
  logic [DATA_W-1:0] ls_data_i;
  logic              ls_full_o;
  logic              cdb_en_o;
  logic [ID_W-1:0]   cdb_id_o;
  logic [DATA_W-1:0] cdb_data_o;
  logic [DATA_W-1:0] cdb_pc_o;
  logic              cdb_cond_o;
  logic              cdb_src_o;

  modport slave (
    input  rdy, clr_i,
    input  alu_en_i, alu_id_i, alu_data_i, alu_pc_i, alu_cond_i,
    input  ls_en_i, ls_id_i, ls_data_i,
    output alu_full_o, ls_full_o,
    output cdb_en_o, cdb_id_o, cdb_data_o, cdb_pc_o, cdb_cond_o, cdb_src_o
  );

  modport master (
    output rdy, clr_i,
    output alu_en_i, alu_id_i, alu_data_i, alu_pc_i, alu_cond_i,
    output ls_en_i, ls_id_i, ls_data_i,
    input  alu_full_o, ls_full_o,
    input  cdb_en_o, cdb_id_o, cdb_data_o, cdb_pc_o, cdb_cond_o, cdb_src_o
  );
endinterface

// File: rtl/cdb_src_fifo.sv
// Per-source circular result queue. Push while full is dropped; clr empties the
// queue and wins over any push/pop in the same cycle. Head is read combinationally.
module cdb_src_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] data_in,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         valid,
  output logic         full,
  input  logic         clr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign full    = (count == DEPTH_C);
  assign do_push = push & ~full & ~clr;
  assign do_pop  = pop & valid & ~clr;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; power-of-two DEPTH makes the wrap free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Single common data bus: ALU and LS results are queued per source, a
// round-robin arbiter picks one head per cycle and the winner is broadcast
// from registered outputs. rdy=0 freezes everything; clr_i flushes both queues.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ID_W   = ROB_ADDR_W,
  parameter int DATA_W = DATA_BUS_W,
  parameter int DEPTH  = 2
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave bus
);

  localparam int ALU_W = ID_W + 2*DATA_W + 1;
  localparam int LS_W  = ID_W + DATA_W;

  logic [ALU_W-1:0]  alu_head;
  logic [LS_W-1:0]   ls_head;
  logic              alu_valid, ls_valid;
  logic              alu_full, ls_full;
  logic              alu_push, ls_push;
  logic              alu_pop, ls_pop;
  logic              q_clr, advance;
  logic              gnt_valid;
  src_e              gnt_src;
  src_e              rr_last;

  logic              nxt_en;
  logic [ID_W-1:0]   nxt_id;
  logic [DATA_W-1:0] nxt_data;
  logic [DATA_W-1:0] nxt_pc;
  logic              nxt_cond;
  src_e              nxt_src;

  logic              cdb_en;
  logic [ID_W-1:0]   cdb_id;
  logic [DATA_W-1:0] cdb_data;
  logic [DATA_W-1:0] cdb_pc;
  logic              cdb_cond;
  src_e              cdb_src;

  assign q_clr    = bus.rdy & bus.clr_i;
  assign advance  = bus.rdy & ~bus.clr_i;
  assign alu_push = bus.rdy & bus.alu_en_i;
  assign ls_push  = bus.rdy & bus.ls_en_i;
  assign alu_pop  = advance & gnt_valid & (gnt_src == SRC_ALU);
  assign ls_pop   = advance & gnt_valid & (gnt_src == SRC_LS);

  cdb_src_fifo #(.W(ALU_W), .DEPTH(DEPTH)) u_alu_q (
    .clk     (clk),
    .rst     (rst),
    .push    (alu_push),
    .data_in ({bus.alu_id_i, bus.alu_data_i, bus.alu_pc_i, bus.alu_cond_i}),
    .pop     (alu_pop),
    .head    (alu_head),
    .valid   (alu_valid),
    .full    (alu_full),
    .clr     (q_clr)
  );

  cdb_src_fifo #(.W(LS_W), .DEPTH(DEPTH)) u_ls_q (
    .clk     (clk),
    .rst     (rst),
    .push    (ls_push),
    .data_in ({bus.ls_id_i, bus.ls_data_i}),
    .pop     (ls_pop),
    .head    (ls_head),
    .valid   (ls_valid),
    .full    (ls_full),
    .clr     (q_clr)
  );

  // Grant: a lone valid head wins outright; a tie goes to the source that is not rr_last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_src   = SRC_ALU;
    if (alu_valid && ls_valid) begin
      gnt_valid = 1'b1;
      gnt_src   = rr_pick(rr_last);
    end else if (alu_valid) begin
      gnt_valid = 1'b1;
      gnt_src   = SRC_ALU;
    end else if (ls_valid) begin
      gnt_valid = 1'b1;
      gnt_src   = SRC_LS;
    end
  end

  // Next broadcast from the granted head; LS carries no pc/cond so those stay 0.
  always_comb begin
    nxt_en   = 1'b0;
    nxt_id   = '0;
    nxt_data = '0;
    nxt_pc   = '0;
    nxt_cond = 1'b0;
    nxt_src  = SRC_ALU;
    if (gnt_valid) begin
      nxt_en  = 1'b1;
      nxt_src = gnt_src;
      if (gnt_src == SRC_ALU) begin
        {nxt_id, nxt_data, nxt_pc, nxt_cond} = alu_head;
      end else begin
        {nxt_id, nxt_data} = ls_head;
      end
    end
  end

  // Broadcast registers and round-robin state; only a tie moves rr_last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_en   <= 1'b0;
      cdb_id   <= '0;
      cdb_data <= '0;
      cdb_pc   <= '0;
      cdb_cond <= 1'b0;
      cdb_src  <= SRC_ALU;
      rr_last  <= SRC_LS;
    end else if (bus.rdy) begin
      if (bus.clr_i) begin
        cdb_en   <= 1'b0;
        cdb_id   <= '0;
        cdb_data <= '0;
        cdb_pc   <= '0;
        cdb_cond <= 1'b0;
        cdb_src  <= SRC_ALU;
        rr_last  <= SRC_LS;
      end else begin
        cdb_en   <= nxt_en;
        cdb_id   <= nxt_id;
        cdb_data <= nxt_data;
        cdb_pc   <= nxt_pc;
        cdb_cond <= nxt_cond;
        cdb_src  <= nxt_src;
        if (alu_valid && ls_valid) rr_last <= gnt_src;
      end
    end
  end

  assign bus.alu_full_o = alu_full;
  assign bus.ls_full_o  = ls_full;
  assign bus.cdb_en_o   = cdb_en;
  assign bus.cdb_id_o   = cdb_id;
  assign bus.cdb_data_o = cdb_data;
  assign bus.cdb_pc_o   = cdb_pc;
  assign bus.cdb_cond_o = cdb_cond;
  assign bus.cdb_src_o  = cdb_src;

endmodule
